icache_refill_unit: RTL and testbench

Services instruction-cache misses raised by the fetch unit. Captures the missing tag/index, issues one line read to the memory side, assembles four 64-bit beats into a 256-bit cacheline, and returns it on the fetch unit's cache-update port with a one-cycle `cacheUpdateEnable_o` pulse. It sits between the fetch unit's miss outputs and the memory/L2 read port, and handles one outstanding miss at a time.

---
 rtl/icache_refill_unit_pkg.sv | 19 +
 rtl/icache_refill_unit_line_assembler.sv | 29 ++
 rtl/icache_refill_unit.sv | 180 ++++++++++++++++++
 tb/tb_icache_refill_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_unit_pkg.sv
// Shared constants and state encoding for the instruction-cache refill unit.
package icache_refill_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_DATA   = 2'd2,
        ST_UPDATE = 2'd3
    } refill_state_e;

    localparam int LINE_BITS        = 256;
    localparam int BEAT_BITS        = 64;
    localparam int BEATS_PER_LINE   = 4;
    localparam int ADDR_BITS        = 64;
    localparam int TAG_WIDTH_DEF    = 51;
    localparam int INDEX_WIDTH_DEF  = 8;
    localparam int OFFSET_WIDTH_DEF = 5;

endpackage

// File: rtl/icache_refill_unit_line_assembler.sv
// Collects 64-bit beats into a 256-bit line; beat k lands in line[64k : 64k+63].
module refill_line_assembler
    import icache_refill_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [0:BEAT_BITS-1]   wr_data,
    output logic [0:LINE_BITS-1]   line
);

    logic [7:0] base;

    assign base = {wr_idx, 6'd0};

    // Line register: cleared at refill start, written one beat at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else if (wr_en) begin
            line[base +: BEAT_BITS] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// Instruction-cache miss refill: one line read, four beats, one update strobe.
// Optional build macro REFILL_TIMEOUT_EN aborts a refill that stalls for TIMEOUT_CYCLES.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
#(
    parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
    parameter int INDEX_WIDTH    = INDEX_WIDTH_DEF,
    parameter int OFFSET_WIDTH   = OFFSET_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    isCacheMiss_i,
    input  logic [0:TAG_WIDTH-1]    missTag_i,
    input  logic [0:INDEX_WIDTH-1]  missIndex_i,
    output logic                    memReadReq_o,
    output logic [0:ADDR_BITS-1]    memAddr_o,
    input  logic                    memReadAck_i,
    input  logic                    memDataValid_i,
    input  logic [0:BEAT_BITS-1]    memData_i,
    output logic [0:TAG_WIDTH-1]    newTag_o,
    output logic [0:INDEX_WIDTH-1]  newIndex_o,
    output logic [0:OFFSET_WIDTH-1] newOffset_o,
    output logic [0:LINE_BITS-1]    newCacheline_o,
    output logic                    cacheUpdateEnable_o,
    output logic                    busy_o,
    output logic                    refillError_o
);

    refill_state_e            state_r, state_nxt_s;
    logic [0:TAG_WIDTH-1]     tag_r, tag_nxt_s;
    logic [0:INDEX_WIDTH-1]   index_r, index_nxt_s;
    logic                     armed_r;
    logic [1:0]               beat_cnt_r;
    logic                     latch_s, beat_s, timeout_s;
    logic                     req_nxt_s, upd_nxt_s, busy_nxt_s;
    logic [0:ADDR_BITS-1]     addr_nxt_s;
    logic [0:TAG_WIDTH-1]     new_tag_nxt_s;
    logic [0:INDEX_WIDTH-1]   new_index_nxt_s;

    assign latch_s     = (state_r == ST_IDLE) && isCacheMiss_i && armed_r;
    assign beat_s      = (state_r == ST_DATA) && memDataValid_i;
    assign tag_nxt_s   = latch_s ? missTag_i : tag_r;
    assign index_nxt_s = latch_s ? missIndex_i : index_r;
    assign newOffset_o = '0;

`ifdef REFILL_TIMEOUT_EN
    localparam int PROG_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [PROG_BITS-1:0] prog_cnt_r;
    logic                 progress_s, waiting_s;

    assign waiting_s  = (state_r == ST_REQ) || (state_r == ST_DATA);
    assign progress_s = latch_s || ((state_r == ST_REQ) && memReadAck_i) || beat_s;
    assign timeout_s  = waiting_s && !progress_s &&
                        (prog_cnt_r == PROG_BITS'(TIMEOUT_CYCLES - 1));

    // Progress watchdog: restarts on any ack or beat, idles outside REQ/DATA.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prog_cnt_r <= '0;
        end else if (progress_s || timeout_s || !waiting_s) begin
            prog_cnt_r <= '0;
        end else begin
            prog_cnt_r <= prog_cnt_r + 1'b1;
        end
    end
`else
    // Without the watchdog a refill never aborts; the comparison is constant false.
    assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = latch_s ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                if (timeout_s)         state_nxt_s = ST_IDLE;
                else if (memReadAck_i) state_nxt_s = ST_DATA;
                else                   state_nxt_s = ST_REQ;
            end
            ST_DATA: begin
                if (timeout_s)
                    state_nxt_s = ST_IDLE;
                else if (beat_s && (beat_cnt_r == 2'(BEATS_PER_LINE - 1)))
                    state_nxt_s = ST_UPDATE;
                else
                    state_nxt_s = ST_DATA;
            end
            ST_UPDATE: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Miss capture, beat counter and re-arm tracking; a held miss level stays disarmed.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            tag_r      <= '0;
            index_r    <= '0;
            beat_cnt_r <= 2'd0;
            armed_r    <= 1'b1;
        end else begin
            tag_r   <= tag_nxt_s;
            index_r <= index_nxt_s;
            if (latch_s || timeout_s) begin
                beat_cnt_r <= 2'd0;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + 2'd1;
            end
            if (timeout_s || latch_s) begin
                armed_r <= 1'b0;
            end else if (!isCacheMiss_i) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        req_nxt_s       = (state_nxt_s == ST_REQ);
        upd_nxt_s       = (state_nxt_s == ST_UPDATE);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        addr_nxt_s      = '0;
        new_tag_nxt_s   = '0;
        new_index_nxt_s = '0;
        if (req_nxt_s) begin
            addr_nxt_s = ADDR_BITS'({tag_nxt_s, index_nxt_s, {OFFSET_WIDTH{1'b0}}});
        end else begin
            addr_nxt_s = '0;
        end
        if (upd_nxt_s) begin
            new_tag_nxt_s   = tag_nxt_s;
            new_index_nxt_s = index_nxt_s;
        end else begin
            new_tag_nxt_s   = '0;
            new_index_nxt_s = '0;
        end
    end

    // Output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            memReadReq_o        <= 1'b0;
            memAddr_o           <= '0;
            cacheUpdateEnable_o <= 1'b0;
            newTag_o            <= '0;
            newIndex_o          <= '0;
            busy_o              <= 1'b0;
            refillError_o       <= 1'b0;
        end else begin
            memReadReq_o        <= req_nxt_s;
            memAddr_o           <= addr_nxt_s;
            cacheUpdateEnable_o <= upd_nxt_s;
            newTag_o            <= new_tag_nxt_s;
            newIndex_o          <= new_index_nxt_s;
            busy_o              <= busy_nxt_s;
            refillError_o       <= timeout_s;
        end
    end

    refill_line_assembler u_line (
        .clk     (clock_i),
        .rst     (reset_i),
        .clear   (latch_s || timeout_s),
        .wr_en   (beat_s),
        .wr_idx  (beat_cnt_r),
        .wr_data (memData_i),
        .line    (newCacheline_o)
    );

endmodule

// File: tb/tb_icache_refill_unit.sv
// Scoreboard bench for icache_refill_unit: expected requests/updates queued by the driver, checked by a monitor.
module tb_icache_refill_unit;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          isCacheMiss_i = 1'b0;
    logic [50:0]   missTag_i = '0;
    logic [7:0]    missIndex_i = '0;
    logic          memReadReq_o;
    logic [63:0]   memAddr_o;
    logic          memReadAck_i = 1'b0;
    logic          memDataValid_i = 1'b0;
    logic [63:0]   memData_i = '0;
    logic [50:0]   newTag_o;
    logic [7:0]    newIndex_o;
    logic [4:0]    newOffset_o;
    logic [255:0]  newCacheline_o;
    logic          cacheUpdateEnable_o;
    logic          busy_o;
    logic          refillError_o;

    icache_refill_unit dut (
        .clock_i(clock_i), .reset_i(reset_i), .isCacheMiss_i(isCacheMiss_i),
        .missTag_i(missTag_i), .missIndex_i(missIndex_i), .memReadReq_o(memReadReq_o),
        .memAddr_o(memAddr_o), .memReadAck_i(memReadAck_i), .memDataValid_i(memDataValid_i),
        .memData_i(memData_i), .newTag_o(newTag_o), .newIndex_o(newIndex_o),
        .newOffset_o(newOffset_o), .newCacheline_o(newCacheline_o),
        .cacheUpdateEnable_o(cacheUpdateEnable_o), .busy_o(busy_o), .refillError_o(refillError_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [50:0]  tag;
        logic [7:0]   idx;
        logic [255:0] line;
    } upd_t;

    upd_t        upd_q[$];
    logic [63:0] addr_q[$];
    logic [63:0] beats_g[4];
    int total = 0, bad = 0;
    int cyc = 0, upd_seen = 0, req_seen = 0, err_seen = 0, exp_upd = 0, exp_err = 0;
    int upd_cycle = 0, miss_cyc = 0, last_beat_cyc = 0;
    logic prev_upd = 1'b0, prev_req = 1'b0, prev_err = 1'b0;

    always @(posedge clock_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference line address: tag, index, then a zero byte offset within the 32-byte line.
    function automatic logic [63:0] line_addr(input logic [50:0] tag, input logic [7:0] idx);
        return (64'(tag) << 13) + (64'(idx) * 64'd32);
    endfunction

    // Monitor: compares every new request and every update strobe with the queued expectations.
    always @(negedge clock_i) begin
        upd_t e;
        logic [63:0] a;
        if (memReadReq_o && !prev_req) begin
            req_seen++;
            if (addr_q.size() == 0) begin
                chk("unexpected_req", 256'(memReadReq_o), 256'd0);
            end else begin
                a = addr_q.pop_front();
                chk("req_addr", 256'(memAddr_o), 256'(a));
            end
        end
        if (cacheUpdateEnable_o) begin
            upd_seen++;
            upd_cycle = cyc;
            chk("upd_width", 256'(prev_upd), 256'd0);
            if (upd_q.size() == 0) begin
                chk("unexpected_upd", 256'(cacheUpdateEnable_o), 256'd0);
            end else begin
                e = upd_q.pop_front();
                chk("upd_tag", 256'(newTag_o), 256'(e.tag));
                chk("upd_index", 256'(newIndex_o), 256'(e.idx));
                chk("upd_offset", 256'(newOffset_o), 256'd0);
                chk("upd_line", newCacheline_o, e.line);
            end
        end else begin
            chk("idle_tag_index", 256'({newTag_o, newIndex_o}), 256'd0);
        end
        if (refillError_o && !prev_err) err_seen++;
        prev_upd = cacheUpdateEnable_o;
        prev_req = memReadReq_o;
        prev_err = refillError_o;
    end

    task automatic raise_miss(input logic [50:0] tag, input logic [7:0] idx);
        missTag_i     = tag;
        missIndex_i   = idx;
        isCacheMiss_i = 1'b1;
        miss_cyc      = cyc;
        addr_q.push_back(line_addr(tag, idx));
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clock_i);
            n++;
        end while (!memReadReq_o && n < 40);
        if (!memReadReq_o) chk("req_timeout", 256'(memReadReq_o), 256'd1);
    endtask

    // One refill: optional miss raise, request wait, delayed ack, gapped beats, optional busy-time miss.
    task automatic refill(input logic [50:0] tag, input logic [7:0] idx, input int ack_dly,
                          input int gap, input bit do_raise, input bit keep_miss,
                          input bit busy_miss, input logic [7:0] busy_idx);
        int seen0;
        if (do_raise) raise_miss(tag, idx);
        upd_q.push_back('{tag, idx, {beats_g[0], beats_g[1], beats_g[2], beats_g[3]}});
        exp_upd++;
        seen0 = upd_seen;
        wait_req();
        if (!keep_miss) isCacheMiss_i = 1'b0;
        repeat (ack_dly) begin
            memDataValid_i = 1'($urandom_range(0, 1));
            memData_i      = {$urandom, $urandom};
            @(negedge clock_i);
        end
        memDataValid_i = 1'b0;
        memReadAck_i   = 1'b1;
        @(negedge clock_i);
        memReadAck_i   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (gap) @(negedge clock_i);
            if (busy_miss && k == 2) raise_miss(tag, busy_idx);
            memDataValid_i = 1'b1;
            memData_i      = beats_g[k];
            last_beat_cyc  = cyc;
            @(negedge clock_i);
            memDataValid_i = 1'b0;
            memData_i      = {$urandom, $urandom};
        end
        repeat (2) @(negedge clock_i);
        #1;
        chk("upd_count", 256'(upd_seen - seen0), 256'd1);
        chk("upd_after_last_beat", 256'(upd_cycle - last_beat_cyc), 256'd1);
    endtask

    task automatic rand_beats();
        for (int k = 0; k < 4; k++) beats_g[k] = {$urandom, $urandom};
    endtask

    initial begin
        int reqs0, upds0;
        repeat (3) @(negedge clock_i);
        chk("reset_outs", 256'({memReadReq_o, memAddr_o, cacheUpdateEnable_o, busy_o,
                               refillError_o, newTag_o, newIndex_o}), 256'd0);
        chk("reset_line", newCacheline_o, 256'd0);
        reset_i = 1'b0;
        @(negedge clock_i);

        // Basic refill with fixed beats and minimum latency.
        beats_g[0] = 64'hFFFFFFFF_EEEEEEEE; beats_g[1] = 64'hDDDDDDDD_CCCCCCCC;
        beats_g[2] = 64'hBBBBBBBB_AAAAAAAA; beats_g[3] = 64'h99999999_88888888;
        refill(51'd5, 8'd8, 0, 0, 1'b1, 1'b0, 1'b0, 8'd0);
        chk("min_latency", 256'(upd_cycle - miss_cyc), 256'd6);
        chk("busy_after", 256'(busy_o), 256'd0);

        // Gapped beats and delayed ack; same data.
        refill(51'd5, 8'd8, 3, 2, 1'b1, 1'b0, 1'b0, 8'd0);

        // Held miss must not re-trigger until it drops.
        rand_beats();
        refill(51'd5, 8'd8, 1, 0, 1'b1, 1'b1, 1'b0, 8'd0);
        reqs0 = req_seen;
        repeat (10) @(negedge clock_i);
        chk("held_no_req", 256'(req_seen - reqs0), 256'd0);
        chk("held_idle", 256'(busy_o), 256'd0);
        isCacheMiss_i = 1'b0;
        @(negedge clock_i);
        rand_beats();
        refill(51'd5, 8'd9, 0, 1, 1'b1, 1'b0, 1'b0, 8'd0);

        // Miss raised while busy is serviced after the current refill.
        upds0 = upd_seen;
        rand_beats();
        refill(51'h7_1234_5678_9ABC, 8'd200, 2, 1, 1'b1, 1'b0, 1'b1, 8'd3);
        rand_beats();
        refill(51'h7_1234_5678_9ABC, 8'd3, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("busy_miss_two_upds", 256'(upd_seen - upds0), 256'd2);

        // Randomized refills.
        for (int r = 0; r < 8; r++) begin
            rand_beats();
            refill(51'({$urandom, $urandom}), 8'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), 1'b1, 1'b0, 1'b0, 8'd0);
        end

        // Reset in the middle of DATA after two beats.
        upds0 = upd_seen;
        raise_miss(51'd77, 8'd42);
        wait_req();
        isCacheMiss_i = 1'b0;
        memReadAck_i  = 1'b1;
        @(negedge clock_i);
        memReadAck_i  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            memDataValid_i = 1'b1;
            memData_i      = {$urandom, $urandom};
            @(negedge clock_i);
        end
        memDataValid_i = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("midreset_outs", 256'({memReadReq_o, memAddr_o, cacheUpdateEnable_o, busy_o,
                                  refillError_o, newTag_o, newIndex_o}), 256'd0);
        chk("midreset_line", newCacheline_o, 256'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        repeat (10) @(negedge clock_i);
        chk("midreset_no_upd", 256'(upd_seen - upds0), 256'd0);

`ifdef REFILL_TIMEOUT_EN
        // No ack for longer than the timeout: one error pulse, back to idle, no update.
        upds0 = upd_seen;
        raise_miss(51'd9, 8'd1);
        wait_req();
        isCacheMiss_i = 1'b0;
        repeat (300) @(negedge clock_i);
        exp_err = 1;
        chk("timeout_idle", 256'({busy_o, memReadReq_o}), 256'd0);
        chk("timeout_no_upd", 256'(upd_seen - upds0), 256'd0);
        rand_beats();
        refill(51'd9, 8'd2, 0, 0, 1'b1, 1'b0, 1'b0, 8'd0);
`endif

        repeat (3) @(negedge clock_i);
        #1;
        chk("err_pulses", 256'(err_seen), 256'(exp_err));
        chk("total_upds", 256'(upd_seen), 256'(exp_upd));
        chk("queues_drained", 256'(upd_q.size() + addr_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
